// File: rtl/lr35902_int_ctrl_pkg.sv
// Shared constants for the LR35902 interrupt controller: default source count,
// vector base, register address selects and FSM state encodings.
package lr35902_int_ctrl_pkg;

    localparam int         IRQ_COUNT    = 5;
    localparam logic [7:0] INT_VEC_BASE = 8'h40;

    localparam logic ADR_IF = 1'b0;
    localparam logic ADR_IE = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

endpackage

// File: rtl/lr35902_int_prio.sv
// Lowest-set-bit encoder: bit 0 of the pending vector is the highest priority.
module lr35902_int_prio #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     pending,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lr35902_int_ctrl.sv
// Interrupt controller: edge-detected request latch (IF), enable mask (IE),
// prioritised req/ack offer to the CPU and a HALT wake flag.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | no interrupt offered; waiting for pending & enabled IF bit
//  REQ     | int_req high, int_vec fixed until ack or software cancel
module lr35902_int_ctrl
    import lr35902_int_ctrl_pkg::*;
#(
    parameter int         NUM_IRQ  = IRQ_COUNT,
    parameter logic [7:0] VEC_BASE = INT_VEC_BASE
) (
    input  logic               clk,
    input  logic               reset,
    output logic [7:0]         dout,
    input  logic [7:0]         din,
    input  logic               adr,
    input  logic               read,
    input  logic               write,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               int_req,
    output logic [7:0]         int_vec,
    input  logic               int_ack,
    output logic               wake
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] if_reg;
    logic [NUM_IRQ-1:0] if_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] pending;
    logic [7:0]         ie_reg;
    logic [7:0]         if_rd;
    logic [0:0]         state;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   prio_idx;
    logic               prio_valid;
    logic               ack_fire;

    assign set_vec  = irq_in & ~irq_prev;
    assign pending  = if_reg & ie_reg[NUM_IRQ-1:0];
    assign wake     = |pending;
    assign ack_fire = (state == ST_REQ) && int_ack;

    lr35902_int_prio #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .pending (pending),
        .idx     (prio_idx),
        .valid   (prio_valid)
    );

    // Software write, then ack clear, then hardware set: set always wins.
    always_comb begin
        if_next = if_reg;
        if (write && (adr == ADR_IF)) begin
            if_next = din[NUM_IRQ-1:0];
        end
        if (ack_fire) begin
            if_next[cur_idx] = 1'b0;
        end
        if_next = if_next | set_vec;
    end

    always_comb begin
        if_rd                = '1;
        if_rd[NUM_IRQ-1:0]   = if_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_reg   <= '0;
            ie_reg   <= '0;
            irq_prev <= '0;
            dout     <= '0;
        end else begin
            if_reg   <= if_next;
            irq_prev <= irq_in;
            if (write && (adr == ADR_IE)) begin
                ie_reg <= din;
            end
            if (read) begin
                dout <= (adr == ADR_IE) ? ie_reg : if_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
            int_vec <= VEC_BASE;
            cur_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (prio_valid) begin
                        cur_idx <= prio_idx;
                        int_vec <= VEC_BASE + (8'(prio_idx) << 3);
                        int_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A newly arrived higher-priority source waits for this ack.
                    if (int_ack) begin
                        int_req <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (!if_reg[cur_idx] || !ie_reg[cur_idx]) begin
                        int_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    int_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lr35902_int_ctrl.sv
// Self-checking bench for lr35902_int_ctrl: table of per-cycle vectors plus
// hand-written multi-cycle sequences, expectations routed through a scoreboard.
module tb_lr35902_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dout;
    logic [7:0] din;
    logic       adr;
    logic       read;
    logic       write;
    logic [4:0] irq_in;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_ack;
    logic       wake;

    lr35902_int_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .dout    (dout),
        .din     (din),
        .adr     (adr),
        .read    (read),
        .write   (write),
        .irq_in  (irq_in),
        .int_req (int_req),
        .int_vec (int_vec),
        .int_ack (int_ack),
        .wake    (wake)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       adr;
        logic       rd;
        logic       ack;
        logic [7:0] din;
        logic [4:0] irq;
        logic       req;
        logic [7:0] vec;
        logic       wk;
        logic [7:0] dout;
    } vec_t;

    typedef struct {
        int         step;
        logic       req;
        logic [7:0] vec;
        logic       wk;
        logic [7:0] dout;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    function automatic vec_t mk(input logic rst, input logic wr, input logic a, input logic rd,
                                input logic ack, input logic [7:0] d, input logic [4:0] irq,
                                input logic req, input logic [7:0] vec, input logic wk,
                                input logic [7:0] dt);
        vec_t v;
        v.rst = rst; v.wr = wr; v.adr = a; v.rd = rd; v.ack = ack; v.din = d; v.irq = irq;
        v.req = req; v.vec = vec; v.wk = wk; v.dout = dt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset   = v.rst;
        write   = v.wr;
        adr     = v.adr;
        read    = v.rd;
        int_ack = v.ack;
        din     = v.din;
        irq_in  = v.irq;
        e.step = step_no; e.req = v.req; e.vec = v.vec; e.wk = v.wk; e.dout = v.dout;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard empty at step %0d", step_no);
        end else begin
            got = sb.pop_front();
            checks++;
            if (int_req !== got.req) begin
                failures++;
                $display("FAIL step%0d int_req got %b want %b", got.step, int_req, got.req);
            end
            checks++;
            if (int_vec !== got.vec) begin
                failures++;
                $display("FAIL step%0d int_vec got %h want %h", got.step, int_vec, got.vec);
            end
            checks++;
            if (wake !== got.wk) begin
                failures++;
                $display("FAIL step%0d wake got %b want %b", got.step, wake, got.wk);
            end
            checks++;
            if (dout !== got.dout) begin
                failures++;
                $display("FAIL step%0d dout got %h want %h", got.step, dout, got.dout);
            end
        end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; adr = 1'b0; read = 1'b0;
        int_ack = 1'b0; din = 8'h00; irq_in = 5'h00;
        repeat (2) @(posedge clk);

        //                rst wr a rd ack din    irq     req vec    wk dout
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 5'h00, 0, 8'h40, 0, 8'h00));
        // serial pulse, IE=08
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'h08, 5'h00, 0, 8'h40, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h08, 0, 8'h40, 1, 8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 1, 8'h58, 1, 8'hE8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h58, 0, 8'hE8));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 0, 8'h58, 0, 8'hE0));
        // two sources together
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'h1F, 5'h00, 0, 8'h58, 0, 8'hE0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h05, 0, 8'h58, 1, 8'hE0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h05, 1, 8'h40, 1, 8'hE0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h40, 1, 8'hE0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h50, 1, 8'hE0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 1, 8'h50, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h50, 0, 8'hE4));
        // higher priority arrives while offering idx 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h08, 0, 8'h50, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h58, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h01, 1, 8'h58, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h58, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h58, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h40, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h40, 0, 8'hE4));
        // write IF=0 while irq 2 rises
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 5'h04, 0, 8'h40, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 1, 8'h50, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h50, 0, 8'hE4));
        // masked pending, enable, cancel by IE clear
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 5'h00, 0, 8'h50, 0, 8'hE4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h02, 5'h00, 0, 8'h50, 0, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 0, 8'h50, 0, 8'hE4));
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'h02, 5'h00, 0, 8'h50, 1, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h48, 1, 8'hE4));
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 5'h00, 1, 8'h48, 0, 8'hE4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 0, 8'h48, 0, 8'hE2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 5'h00, 0, 8'h48, 0, 8'h00));
        // ack in IDLE must not touch IF; upper IE bits read back
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h00, 5'h00, 0, 8'h48, 0, 8'hE2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 0, 8'h48, 0, 8'hE2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'hE0, 5'h00, 0, 8'h48, 0, 8'hE2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 5'h00, 0, 8'h48, 0, 8'hE0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // level source held 10 cycles sets IF once; ack clears it for good
        apply(mk(0, 1, 0, 0, 0, 8'h00, 5'h00, 0, 8'h48, 0, 8'hE0));
        apply(mk(0, 1, 1, 0, 0, 8'h10, 5'h00, 0, 8'h48, 0, 8'hE0));
        for (int i = 0; i < 10; i++) begin
            apply(mk(0, 0, 0, 0, (i == 2), 8'h00, 5'h10,
                     (i == 1), (i == 0) ? 8'h48 : 8'h60, (i <= 1), 8'hE0));
        end
        apply(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 0, 8'h60, 0, 8'hE0));

        // reset while offering
        apply(mk(0, 0, 0, 0, 0, 8'h00, 5'h10, 0, 8'h60, 1, 8'hE0));
        apply(mk(0, 0, 0, 0, 0, 8'h00, 5'h10, 1, 8'h60, 1, 8'hE0));
        apply(mk(1, 0, 0, 0, 0, 8'h00, 5'h00, 0, 8'h40, 0, 8'h00));
        apply(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 0, 8'h40, 0, 8'hE0));
        apply(mk(0, 0, 1, 1, 0, 8'h00, 5'h00, 0, 8'h40, 0, 8'h00));

        // write + ack + set in one cycle, then set beating an ack clear
        apply(mk(0, 1, 1, 0, 0, 8'h1F, 5'h00, 0, 8'h40, 0, 8'h00));
        apply(mk(0, 0, 0, 0, 0, 8'h00, 5'h02, 0, 8'h40, 1, 8'h00));
        apply(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h48, 1, 8'h00));
        apply(mk(0, 1, 0, 0, 1, 8'h03, 5'h04, 0, 8'h48, 1, 8'h00));
        apply(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 1, 8'h40, 1, 8'hE5));
        apply(mk(0, 0, 0, 0, 1, 8'h00, 5'h00, 0, 8'h40, 1, 8'hE5));
        apply(mk(0, 0, 0, 0, 0, 8'h00, 5'h00, 1, 8'h50, 1, 8'hE5));
        apply(mk(0, 0, 0, 0, 1, 8'h00, 5'h04, 0, 8'h50, 1, 8'hE5));
        apply(mk(0, 0, 0, 1, 0, 8'h00, 5'h00, 1, 8'h50, 1, 8'hE4));

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard leftover got %0d want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
